// File: rtl/vga_stream_decoder.sv
// vga_stream_decoder: VGA sink that rebuilds pixel coordinates from sync edges,
// tracks line/frame timing lock and captures one probe pixel per frame.
module vga_stream_decoder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk_25mHz,
  input  logic        reset_n,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb_in,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic [9:0]  x_out,
  output logic [8:0]  y_out,
  output logic        de,
  output logic [11:0] rgb_out,
  output logic        locked,
  output logic [11:0] probe_color,
  output logic        probe_valid,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [9:0] H_LAST = 10'(H_FP + H_SYNC + H_BP + WIDTH - 1);
  localparam logic [9:0] V_LAST = 10'(V_FP + V_SYNC + V_BP + HEIGHT - 1);
  localparam logic [9:0] HA     = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HE     = 10'(H_SYNC + H_BP + WIDTH);
  localparam logic [9:0] VA     = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VE     = 10'(V_SYNC + V_BP + HEIGHT);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  state_t      state_q, state_d;
  logic        hs_q, hs_p_q, vs_q, vs_p_q, vs_arm_q, vs_arm_d;
  logic [11:0] rgb_q;
  logic [9:0]  hcount_q, vcount_q, h_idx, v_idx;
  logic        hs_fall, vs_fall, armed, chk, err;
  logic        de_d, pv_d, fd_d;
  logic [9:0]  x_d;
  logic [8:0]  y_d;
  logic [11:0] rgb_d;
  logic        de_q, locked_q, probe_valid_q, frame_done_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [11:0] rgb_out_q, probe_color_q;
  logic [15:0] frame_count_q;
  logic [7:0]  err_count_q;
  always_comb begin
    hs_fall  = !hs_q && hs_p_q;
    vs_fall  = !vs_q && vs_p_q;
    armed    = hs_fall && (vs_arm_q || vs_fall);
    vs_arm_d = armed ? 1'b0 : (vs_fall || vs_arm_q);
    h_idx    = hs_fall ? '0 : (&hcount_q ? hcount_q : hcount_q + 10'd1);
    v_idx    = armed ? '0 : (hs_fall && !(&vcount_q)) ? vcount_q + 10'd1 : vcount_q;
    chk      = state_q != SEARCH;
    err      = chk && ((hs_fall && hcount_q != H_LAST) || (armed && vcount_q != V_LAST));
    // an error on the same edge as an armed line start wins
    state_d  = err ? SEARCH : !armed ? state_q : (state_q == SEARCH) ? ACQUIRE : LOCKED;
    de_d     = chk && h_idx >= HA && h_idx < HE && v_idx >= VA && v_idx < VE;
    x_d      = de_d ? h_idx - HA : '0;
    y_d      = de_d ? 9'(v_idx - VA) : '0;
    rgb_d    = de_d ? rgb_q : '0;
    pv_d     = state_q == LOCKED && de_d && x_d == probe_x && y_d == probe_y;
    fd_d     = state_q == LOCKED && de_d && x_d == X_LAST && y_d == Y_LAST;
  end
  always_ff @(posedge clk_25mHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b0;
      hs_p_q        <= 1'b0;
      vs_q          <= 1'b0;
      vs_p_q        <= 1'b0;
      vs_arm_q      <= 1'b0;
      rgb_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_out_q     <= '0;
      locked_q      <= 1'b0;
      probe_valid_q <= 1'b0;
      probe_color_q <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      hs_q          <= hSync;
      hs_p_q        <= hs_q;
      vs_q          <= vSync;
      vs_p_q        <= vs_q;
      rgb_q         <= rgb_in;
      vs_arm_q      <= vs_arm_d;
      hcount_q      <= h_idx;
      vcount_q      <= v_idx;
      state_q       <= state_d;
      locked_q      <= state_d == LOCKED;
      if (err && state_q == LOCKED && !(&err_count_q)) err_count_q <= err_count_q + 8'd1;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_out_q     <= rgb_d;
      probe_valid_q <= pv_d;
      if (pv_d) probe_color_q <= rgb_d;
      frame_done_q  <= fd_d;
      if (fd_d) frame_count_q <= frame_count_q + 16'd1;
    end
  end
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign de          = de_q;
  assign rgb_out     = rgb_out_q;
  assign locked      = locked_q;
  assign probe_color = probe_color_q;
  assign probe_valid = probe_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
endmodule

// File: doc/vga_stream_decoder.md
Name: vga_stream_decoder

Overview:
Sink side of the 640x480 VGA link. Samples hSync/vSync/12-bit colour on the pixel clock, rebuilds pixel coordinates from the sync edges, checks line and frame timing, and reports lock status. A programmable pixel probe captures the colour at one coordinate per frame. It sits on the video output as an on-board checker and collision-readback source, driven by the same 25 MHz clock as the video generator.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hSync low width
H_BP, 48, horizontal back porch
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vSync low width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk_25mHz  in  1  pixel clock; single clock domain; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
hSync  in  1  horizontal sync, active low
vSync  in  1  vertical sync, active low
rgb_in  in  12  {R,G,B} pixel colour
probe_x  in  10  probe column
probe_y  in  9  probe row
x_out  out  10  column of current decoded pixel
y_out  out  9  row of current decoded pixel
de  out  1  decoded pixel lies in the active area
rgb_out  out  12  colour of decoded pixel; 0 when de=0
locked  out  1  timing locked
probe_color  out  12  last captured probe colour
probe_valid  out  1  one-cycle pulse on capture
frame_done  out  1  one-cycle pulse after pixel (WIDTH-1, HEIGHT-1)
frame_count  out  16  locked frames completed; wraps at 65535 -> 0
err_count  out  8  lock losses; saturates at 255

Behaviour:
- Constants: H_TOT = H_FP+H_SYNC+H_BP+WIDTH (800). V_TOT similarly (525). HA = H_SYNC+H_BP (144). VA = V_SYNC+V_BP (35).
- Reset: every output and register is 0. State is SEARCH. vs_arm is 0.
- Stage 1 registers the pins (hs_q, vs_q, rgb_q) and holds previous hs_q/vs_q.
- hs_fall = hs_q low and previous hs_q high. vs_fall is defined the same way on vs_q.
- vs_fall sets vs_arm. An armed line start is an hs_fall while vs_arm=1, or in the same cycle as vs_fall. It clears vs_arm.
- h_idx = 0 on hs_fall. Otherwise h_idx = hcount+1, saturating at 1023. hcount <= h_idx.
- v_idx = 0 on an armed line start. On any other hs_fall it is vcount+1, saturating at 1023. Otherwise it equals vcount. vcount <= v_idx.
- h_err: hs_fall with hcount != H_TOT-1.
- v_err: armed line start with vcount != V_TOT-1.
- Both error checks are evaluated only in ACQUIRE and LOCKED.
- Stage 2 registers the outputs. Latency from the pins to x_out, y_out, de and rgb_out is exactly 2 clocks.
- de = state != SEARCH and HA <= h_idx < HA+WIDTH and VA <= v_idx < VA+HEIGHT.
- When de=1: x_out = h_idx-HA, y_out = v_idx-VA, rgb_out = rgb_q.
- When de=0: x_out, y_out and rgb_out hold 0.
- State machine:
  - SEARCH -> ACQUIRE on an armed line start. The counters zero as above.
  - ACQUIRE -> SEARCH on h_err or v_err. err_count is unchanged.
  - ACQUIRE -> LOCKED on an armed line start with no v_err (one full good frame).
  - LOCKED -> SEARCH on h_err or v_err. err_count increments (saturating). locked drops on the next cycle.
  - If an error and an armed line start occur in the same cycle, the error wins.
- locked = (state == LOCKED), registered. It rises 1 clock after the qualifying stage-1 edge.
- Probe: in LOCKED, when de, x == probe_x and y == probe_y (stage-2 values):
  - probe_color <= rgb;
  - probe_valid pulses in the same cycle as that stage-2 output.
  - probe_x/probe_y are sampled continuously.
  - An out-of-range probe never fires.
- frame_done pulses in LOCKED in the cycle x_out=WIDTH-1, y_out=HEIGHT-1, de=1. frame_count increments in the same cycle.
- Reset asserted mid-frame clears everything immediately. The block then needs an armed line start plus one full good frame to relock.

Test Plan:
1. Reset, then nominal 800x525 timing with rgb_in = {x[3:0], y[3:0], 4'hA}. Required response:
   - locked rises 1 clock after the second vs-armed hSync fall.
   - Each locked frame has exactly 307200 de cycles.
   - rgb_out at x_out=5, y_out=3 is 12'h53A.
   - de first rises 2 clocks after pin column 144 of line 35.
2. probe_x=100, probe_y=50 while locked -> one probe_valid per frame, probe_color=12'h42A. probe_x=700 -> probe_valid never fires.
3. While locked, shorten one line to 799 clocks -> locked=0, err_count=1, de=0 until the next vs-armed line. locked returns after one further good frame.
4. While locked, send a 524-line frame -> v_err, locked drops, err_count=1. In ACQUIRE the same error leaves err_count unchanged.
5. Locked for 3 frames -> frame_count=3, three frame_done pulses, each coinciding with (639, 479). Then pull reset_n low for 3 clocks mid-line -> all outputs 0 asynchronously, state SEARCH.
6. Force 256 lock losses -> err_count saturates at 255. frame_count preset near 65535 wraps to 0 on the next frame_done.
